// File: rtl/mips_pkg.sv
// Shared MIPS definitions: branch-type encodings, PC sequencer states and the
// default PC value after reset.
package mips_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_JUMP = 2'b11
  } branch_type_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DECODE  = 2'd1,
    RESOLVE = 2'd2
  } state_e;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;

endpackage

// File: rtl/adder.sv
// Branch-target adder: Result = PC + Four + SignExtLeft2 (modulo 2^WORD_LENGTH).
// Ports:
//   PC           current PC
//   Four         increment term (tie to zero when PC is already incremented)
//   SignExtLeft2 sign-extended, word-shifted branch offset
//   Result       sum
module adder #(
  parameter int WORD_LENGTH = 32
) (
  input  logic [WORD_LENGTH-1:0] PC,
  input  logic [WORD_LENGTH-1:0] Four,
  input  logic [WORD_LENGTH-1:0] SignExtLeft2,
  output logic [WORD_LENGTH-1:0] Result
);

  assign Result = PC + Four + SignExtLeft2;

endmodule

// File: rtl/pc_branch_unit.sv
// Multicycle-MIPS program-counter sequencer. Owns the architectural PC,
// increments it on fetch, forms the branch target during decode and resolves
// beq/bne from the ALU Zero flag, or applies a jump.
// Ports:
//   clk, reset        rising-edge clock, async active-low reset
//   Fetch_Valid       instruction fetched at PC (accepted in IDLE only)
//   Branch_Type       00 none, 01 beq, 10 bne, 11 jump (sampled in DECODE)
//   SignExtLeft2      branch offset, already shifted (sampled in DECODE)
//   JumpIndex         instr[25:0] (sampled in DECODE)
//   Zero, Zero_Valid  ALU compare result (accepted in RESOLVE only)
//   PC, Branch_Target registered PC and latched target
//   Taken             one-cycle pulse after a redirect
//   Busy              state != IDLE
//
// state   | meaning
// IDLE    | waiting for a fetch
// DECODE  | PC holds old PC+4; target latched, type captured
// RESOLVE | branch waiting for Zero_Valid
module pc_branch_unit
  import mips_pkg::*;
#(
  parameter int                     WORD_LENGTH = 32,
  parameter logic [WORD_LENGTH-1:0] RESET_PC    = WORD_LENGTH'(DEFAULT_RESET_PC)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   Fetch_Valid,
  input  logic [1:0]             Branch_Type,
  input  logic [WORD_LENGTH-1:0] SignExtLeft2,
  input  logic [25:0]            JumpIndex,
  input  logic                   Zero,
  input  logic                   Zero_Valid,
  output logic [WORD_LENGTH-1:0] PC,
  output logic [WORD_LENGTH-1:0] Branch_Target,
  output logic                   Taken,
  output logic                   Busy
);

  state_e                 r_state, w_state_next;
  branch_type_e           r_type, w_type_next;
  logic [WORD_LENGTH-1:0] r_pc, w_pc_next;
  logic [WORD_LENGTH-1:0] r_target, w_target_next;
  logic                   r_taken, w_taken_next;
  logic [WORD_LENGTH-1:0] w_target_sum;
  logic [WORD_LENGTH-1:0] w_jump_pc;
  logic                   w_br_taken;

  // PC is already PC+4 in DECODE, so the increment input is unused.
  adder #(.WORD_LENGTH(WORD_LENGTH)) u_target_adder (
    .PC           (r_pc),
    .Four         ('0),
    .SignExtLeft2 (SignExtLeft2),
    .Result       (w_target_sum)
  );

  always_comb begin
    w_jump_pc       = r_pc;
    w_jump_pc[27:0] = {JumpIndex, 2'b00};
  end

  assign w_br_taken = ((r_type == BR_BEQ) && Zero) || ((r_type == BR_BNE) && !Zero);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= IDLE;
      r_type   <= BR_NONE;
      r_pc     <= RESET_PC;
      r_target <= '0;
      r_taken  <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_type   <= w_type_next;
      r_pc     <= w_pc_next;
      r_target <= w_target_next;
      r_taken  <= w_taken_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_type_next   = r_type;
    w_pc_next     = r_pc;
    w_target_next = r_target;
    w_taken_next  = 1'b0;
    case (r_state)
      IDLE: begin
        if (Fetch_Valid) begin
          w_pc_next    = r_pc + WORD_LENGTH'(4);
          w_state_next = DECODE;
        end
      end
      DECODE: begin
        w_target_next = w_target_sum;
        w_type_next   = branch_type_e'(Branch_Type);
        case (branch_type_e'(Branch_Type))
          BR_NONE: w_state_next = IDLE;
          BR_JUMP: begin
            w_pc_next    = w_jump_pc;
            w_taken_next = 1'b1;
            w_state_next = IDLE;
          end
          default: w_state_next = RESOLVE;
        endcase
      end
      RESOLVE: begin
        if (Zero_Valid) begin
          if (w_br_taken) begin
            w_pc_next    = r_target;
            w_taken_next = 1'b1;
          end
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  assign PC            = r_pc;
  assign Branch_Target = r_target;
  assign Taken         = r_taken;
  assign Busy          = (r_state != IDLE);

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Multicycle-MIPS program-counter sequencer that consumes branch and jump information and owns the architectural PC register. It is the consuming end of the branch-target path. It latches PC+4 at fetch, forms and holds the branch target (offset + PC + 4) during decode, then resolves beq/bne from the ALU Zero flag or applies a jump before returning to idle. It sits between the control FSM and instruction memory address mux.

## Interface
- WORD_LENGTH, 32, datapath/PC width (≥ 28)
- RESET_PC, 32'h0040_0000, PC value after reset
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- Fetch_Valid  input  1  instruction fetched at current PC this cycle
- Branch_Type  input  2  00 none, 01 beq, 10 bne, 11 jump; sampled in DECODE
- SignExtLeft2  input  WORD_LENGTH  sign-extended offset already shifted left 2; sampled in DECODE
- JumpIndex  input  26  instr[25:0]; sampled in DECODE
- Zero  input  1  ALU zero flag; meaningful only with Zero_Valid
- Zero_Valid  input  1  compare result valid this cycle
- PC  output  WORD_LENGTH  architectural PC, registered
- Branch_Target  output  WORD_LENGTH  latched target, registered
- Taken  output  1  one-cycle pulse: PC was redirected
- Busy  output  1  high whenever state ≠ IDLE

## Operation
- States: IDLE, DECODE, RESOLVE.
- IDLE:
  - Fetch_Valid=1 → PC ← PC+4, state → DECODE.
  - Otherwise hold.
- DECODE, where PC already equals old PC+4:
  - Branch_Target ← SignExtLeft2 + PC. This is numerically offset + old PC + 4.
  - Branch_Type 00 → IDLE.
  - Branch_Type 11 → PC ← {PC[WL-1:28], JumpIndex, 2'b00}, Taken pulse, → IDLE. Branch_Target is still updated.
  - Branch_Type 01/10 → RESOLVE.
- RESOLVE: wait indefinitely for Zero_Valid. When it arrives, the branch is taken for (beq & Zero) | (bne & !Zero).
  - Taken → PC ← Branch_Target, Taken pulse.
  - Not taken → PC unchanged.
  - Either case → IDLE.
- The branch type is captured in DECODE into an internal register; it is not re-sampled in RESOLVE.
- Arithmetic is modulo 2^WORD_LENGTH. PC+4 and target addition wrap silently; there is no overflow flag.
- Fetch_Valid is ignored outside IDLE. Zero_Valid is ignored outside RESOLVE.
- Reset values: PC=RESET_PC, Branch_Target=0, Taken=0, Busy=0, state=IDLE, internal type register=00.

## Timing
- All outputs are registered or decoded from the registered state. There are no combinational paths from inputs to outputs.
- Fetch-to-DECODE: 1 cycle. A non-branch instruction occupies 2 cycles: IDLE accept, DECODE.
- Jump: PC is redirected on the DECODE edge. Taken is high for the following cycle only.
- Branch: minimum 3 cycles: IDLE, DECODE, RESOLVE with Zero_Valid already high.
  - PC is redirected on the RESOLVE edge where Zero_Valid=1.
  - Taken is high for exactly the next cycle.
- Fetch_Valid can be accepted in the same cycle Taken is high, because the state is already IDLE. The fetch then uses the redirected PC.
- Reset asserted mid-operation, in any state: all registers go to reset values immediately (asynchronously). Taken drops without completing its pulse.
- Reset release: the first edge with reset=1 is a normal IDLE cycle.

## Structure
- Shared package `mips_pkg`:
  - Branch_Type encodings: BR_NONE, BR_BEQ, BR_BNE, BR_JUMP.
  - State enum: IDLE, DECODE, RESOLVE.
  - Default RESET_PC constant.
- Sub-module: reuse the existing `adder`.
  - Tie Four to 0.
  - Connect PC = current (already incremented) PC.
  - This forms Branch_Target; the PC+4 increment is a separate inline add.
- The FSM and registers live in pc_branch_unit itself.

## Test plan
- Reset: hold reset=0 → PC=32'h0040_0000, Busy=0, Taken=0, Branch_Target=0. Assert reset mid-RESOLVE → same values on the next sample.
- Non-branch instruction: Fetch_Valid at PC=0x00400000 with Branch_Type=00 → PC=0x00400004 after 1 cycle; Busy high for 1 cycle; Taken never pulses.
- beq taken:
  - Stimulus: fetch at 0x00400010, SignExtLeft2=0xFFFFFFF0, Zero_Valid=1 and Zero=1 two cycles later.
  - Response: Branch_Target=0x00400004 and PC=0x00400004, Taken pulses one cycle.
  - Variant: with Zero=0 → PC stays 0x00400014.
- bne stall:
  - Stimulus: Zero_Valid held low for 5 cycles in RESOLVE, then Zero=0.
  - Response: Busy stays high throughout; PC=target afterwards; Fetch_Valid pulses during the stall are ignored.
- Jump: PC=0x00400020, JumpIndex=26'h0100008 → PC=0x00400020 after DECODE, Taken pulses.
- Wrap-around: RESET_PC=32'hFFFFFFFC, fetch → PC=0x00000000. A target computation of 0x00000000 + 0xFFFFFFF8 → 0xFFFFFFF8.
